stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer with valid/ready handshakes and one registered output stage.
- Successor to the fixed 4-bit combinational muxes: adds a configurable data width and channel count, backpressure, and a choice of two arbitration modes (fixed select or round-robin).
- Sits between several producer streams and a single consumer; reports which channel each output word came from.

Parameters:
- W, 8, data width per channel.
- N, 4, number of input channels (N >= 2; need not be a power of two).
- SELW, $clog2(N), localparam; width of sel and out_ch.

Ports:
- clk, input, 1, clock; all state updates on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, N, per-channel valid.
- in_data, input, N*W, channel i occupies bits [i*W +: W].
- in_ready, output, N, per-channel ready; combinational.
- mode, input, 1, 0 = FIXED (use sel), 1 = RR (round-robin).
- sel, input, SELW, channel select in FIXED mode.
- out_valid, output, 1, registered output valid.
- out_data, output, W, registered output data.
- out_ch, output, SELW, source channel of out_data.
- out_ready, input, 1, consumer ready.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer ptr = N-1, so channel 0 has top priority first.
  - Applies mid-transfer; any held word is discarded.
- Load enable:
  - load = !out_valid || out_ready.
  - A transfer into the output register occurs when load && grant_valid.
- Grant, FIXED mode:
  - g = sel.
  - grant_valid = in_valid[sel] && (sel < N).
  - sel >= N gives no grant.
- Grant, RR mode:
  - g = first i with in_valid[i], scanning (ptr+1) mod N upward with wrap-around.
  - grant_valid = |in_valid.
- Handshake:
  - in_ready[i] = load && grant_valid && (i == g); at most one bit is high.
  - in_ready may depend combinationally on in_valid, mode and sel; out_ready must not feed back to out_valid within the same cycle.
- On transfer: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - In RR mode only, ptr <= g. ptr is frozen in FIXED mode.
- When load && !grant_valid: out_valid <= 0; out_data and out_ch hold their values.
- When out_valid && !out_ready: out_valid, out_data and out_ch are held stable.
- Latency is 1 cycle from input handshake to out_valid. Throughput is 1 word per cycle with out_ready held high.
- A mode or sel change takes effect on the next grant decision. A word already in the output register is unaffected.
- Fairness: in RR mode with all channels valid and out_ready = 1, the grant order is 0,1,...,N-1,0,...
- Output is stable while stalled: a stalled output never changes data.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t.
  - Function next_rr(ptr, valid_vec, N) returning the granted index, usable by the bench model.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], ptr, en. Outputs: gnt_idx, gnt_valid. Purely combinational.
  - Holds the wrap-around priority scan.
- The top level holds the ptr register, the output register, the mode/sel multiplexing and the in_ready decode.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with all inputs valid -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0; then rst_n = 1 in RR mode -> first word comes from channel 0.
- RR fairness: N = 4, W = 8, in_data = {8'h33, 8'h22, 8'h11, 8'h00}, all valid, out_ready = 1 -> out_ch sequence 0,1,2,3,0 and out_data 00,11,22,33,00, one per cycle after 1-cycle latency.
- RR skip: in_valid = 4'b1010, ptr = 1 -> grant channel 3 then 1; in_ready one-hot, matching the granted channel.
- FIXED mode: mode = 0, sel = 2, in_valid = 4'b1111 -> only channel 2 accepted every cycle; ptr unchanged; switch to sel = 0 -> the next word has out_ch = 0.
- Backpressure: out_valid = 1 with out_data = 8'h22, then out_ready = 0 for 3 cycles -> out_data and out_ch stable, in_ready = 0; out_ready = 1 -> word consumed and the next word loaded the same cycle.
- Boundary: N = 3, FIXED mode with sel = 3 -> no grant, out_valid drops after a pending word drains; assert rst_n = 0 while out_valid = 1 -> out_valid = 0 on the next edge.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// The reference scan below is intended for models, not for synthesis of the mux itself.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    localparam int MAX_N = 64;

    // Returns the channel granted after ptr in a wrap-around scan, or -1 if none is valid.
    function automatic int next_rr(input int ptr, input logic [MAX_N-1:0] valid_vec, input int n);
        int c;
        next_rr = -1;
        for (int k = n; k >= 1; k--) begin
            c = (ptr + k) % n;
            if (valid_vec[c]) begin
                next_rr = c;
            end
        end
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational wrap-around priority scan: the first requester strictly after ptr wins.
// N need not be a power of two; candidate indices are folded back into [0, N).
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_valid
);

    logic [SELW-1:0] cand_idx [N];
    logic [N-1:0]    cand_hit;

    // Candidate gi sits at distance gi+1 from ptr; ptr < N keeps the sum below 2N.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [SELW:0] sum;
        logic          hit;

        assign sum = {1'b0, ptr} + (SELW+1)'(gi + 1);
        assign cand_idx[gi] = (sum >= (SELW+1)'(N)) ? SELW'(sum - (SELW+1)'(N))
                                                    : sum[SELW-1:0];

        always_comb begin
            hit = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (cand_idx[gi] == SELW'(j)) begin
                    hit = en && req[j];
                end
            end
        end

        assign cand_hit[gi] = hit;
    end

    // Scan farthest-first so the nearest hit overwrites earlier ones.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                gnt_idx   = cand_idx[k];
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with one registered output stage,
// selectable between a fixed channel select and round-robin arbitration.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      in_valid,
    input  logic [N*W-1:0]    in_data,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    input  logic              out_ready
);

    mux_mode_t       cur_mode;
    logic            load;
    logic            xfer;
    logic [SELW-1:0] g;
    logic            grant_valid;
    logic            fixed_valid;
    logic [SELW-1:0] rr_idx;
    logic            rr_valid;
    logic [W-1:0]    data_sel;

    logic            out_valid_reg, out_valid_next;
    logic [W-1:0]    out_data_reg,  out_data_next;
    logic [SELW-1:0] out_ch_reg,    out_ch_next;
    logic [SELW-1:0] ptr_reg,       ptr_next;

    assign cur_mode = mux_mode_t'(mode);

    // A select value outside [0, N) matches no channel and so never grants.
    always_comb begin
        fixed_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                fixed_valid = in_valid[i];
            end
        end
    end

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_reg),
        .en        (cur_mode == MODE_RR),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    assign g           = (cur_mode == MODE_RR) ? rr_idx   : sel;
    assign grant_valid = (cur_mode == MODE_RR) ? rr_valid : fixed_valid;

    assign load = !out_valid_reg || out_ready;
    assign xfer = load && grant_valid;

    // No handshake is offered while reset is asserted.
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign in_ready[gi] = rst_n && xfer && (g == SELW'(gi));
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) begin
                data_sel = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_ch_next    = out_ch_reg;
        ptr_next       = ptr_reg;
        if (xfer) begin
            out_valid_next = 1'b1;
            out_data_next  = data_sel;
            out_ch_next    = g;
            if (cur_mode == MODE_RR) begin
                ptr_next = g;
            end
        end else if (load) begin
            out_valid_next = 1'b0;
        end
    end

    // Pointer resets to N-1 so that channel 0 is scanned first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            ptr_reg       <= SELW'(N - 1);
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_ch_reg    <= out_ch_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios on N=4 and N=3 instances, plus a
// randomized run against a cycle-level behavioural model of the N=4 instance.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4, W=8 instance
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    // N=3, W=8 instance
    logic        rst3_n;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model of the N=4 instance
    bit       m_valid = 1'b0;
    bit [7:0] m_data  = 8'h00;
    int       m_ch    = 0;
    int       m_ptr   = 3;

    stream_mux_rr #(.W(8), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
    );

    stream_mux_rr #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_valid(out_valid3),
        .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3)
    );

    function automatic void m_grant(output int g, output bit gv);
        g  = 0;
        gv = 1'b0;
        if (mode) begin
            for (int k = 1; k <= 4; k++) begin
                if (!gv && in_valid[(m_ptr + k) % 4]) begin
                    g  = (m_ptr + k) % 4;
                    gv = 1'b1;
                end
            end
        end else begin
            g  = int'(sel);
            gv = in_valid[sel];
        end
    endfunction

    function automatic logic [3:0] m_exp_ready();
        int g;
        bit gv;
        m_grant(g, gv);
        if (rst_n && (!m_valid || out_ready) && gv) return 4'(1 << g);
        return 4'b0000;
    endfunction

    // Advance one clock: model takes the pre-edge inputs; outputs are sampled 1 time unit after.
    task automatic tick();
        int g;
        bit gv;
        bit ld;
        m_grant(g, gv);
        ld = !m_valid || out_ready;
        if (out_valid && out_ready)
            $display("xfer n4 ch=%0d data=%02h t=%0t", out_ch, out_data, $time);
        if (out_valid3 && out_ready3)
            $display("xfer n3 ch=%0d data=%02h t=%0t", out_ch3, out_data3, $time);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 3;
        end else if (ld && gv) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_ch    = g;
            if (mode) m_ptr = g;
        end else if (ld) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'hF; in_data = 32'h33221100;
        mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
        tick(); tick();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", out_valid); end
        compared++; if (out_data !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", out_data); end
        compared++; if (out_ch !== 2'd0) begin mismatched++; $display("FAIL reset_ch got %0d want 0", out_ch); end
        compared++; if (in_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_ready got %b want 0000", in_ready); end
        rst_n = 1'b1; #1;
        compared++; if (in_ready !== 4'b0001) begin mismatched++; $display("FAIL reset_first_ready got %b want 0001", in_ready); end
        tick();
        compared++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h00) begin
            mismatched++; $display("FAIL reset_first_word got v=%b ch=%0d d=%h want v=1 ch=0 d=00", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_rr_fairness();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            compared++;
            if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== 8'((k % 4) * 8'h11)) begin
                mismatched++;
                $display("FAIL rr_fair[%0d] got v=%b ch=%0d d=%h want v=1 ch=%0d d=%02h",
                         k, out_valid, out_ch, out_data, k % 4, (k % 4) * 8'h11);
            end
        end
    endtask

    task automatic test_rr_skip();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        in_valid = 4'b0011; tick(); tick();
        in_valid = 4'b1010; #1;
        compared++; if (in_ready !== 4'b1000) begin mismatched++; $display("FAIL rr_skip_ready0 got %b want 1000", in_ready); end
        tick();
        compared++; if (out_ch !== 2'd3) begin mismatched++; $display("FAIL rr_skip_ch0 got %0d want 3", out_ch); end
        compared++; if (in_ready !== 4'b0010) begin mismatched++; $display("FAIL rr_skip_ready1 got %b want 0010", in_ready); end
        tick();
        compared++; if (out_ch !== 2'd1 || out_data !== 8'h11) begin mismatched++; $display("FAIL rr_skip_ch1 got ch=%0d d=%h want ch=1 d=11", out_ch, out_data); end
    endtask

    task automatic test_fixed();
        // ptr is left at 1 by the previous scenario
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            compared++; if (in_ready !== 4'b0100) begin mismatched++; $display("FAIL fixed_ready[%0d] got %b want 0100", k, in_ready); end
            tick();
            compared++; if (out_ch !== 2'd2 || out_data !== 8'h22) begin mismatched++; $display("FAIL fixed_word[%0d] got ch=%0d d=%h want ch=2 d=22", k, out_ch, out_data); end
        end
        sel = 2'd0; #1;
        compared++; if (in_ready !== 4'b0001) begin mismatched++; $display("FAIL fixed_sel0_ready got %b want 0001", in_ready); end
        tick();
        compared++; if (out_ch !== 2'd0) begin mismatched++; $display("FAIL fixed_sel0_ch got %0d want 0", out_ch); end
        // Back to RR: frozen ptr=1 means channel 2 is next
        mode = 1'b1; tick();
        compared++; if (out_ch !== 2'd2) begin mismatched++; $display("FAIL fixed_ptr_frozen got ch=%0d want 2", out_ch); end
    endtask

    task automatic test_backpressure();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); tick(); tick();
        compared++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin mismatched++; $display("FAIL bp_setup got v=%b d=%h want v=1 d=22", out_valid, out_data); end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (out_valid !== 1'b1 || out_data !== 8'h22 || out_ch !== 2'd2 || in_ready !== 4'b0000) begin
                mismatched++;
                $display("FAIL bp_stall[%0d] got v=%b d=%h ch=%0d rdy=%b want v=1 d=22 ch=2 rdy=0000",
                         k, out_valid, out_data, out_ch, in_ready);
            end
        end
        out_ready = 1'b1; #1;
        compared++; if (in_ready !== 4'b1000) begin mismatched++; $display("FAIL bp_release_ready got %b want 1000", in_ready); end
        tick();
        compared++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h33) begin mismatched++; $display("FAIL bp_release_word got v=%b ch=%0d d=%h want v=1 ch=3 d=33", out_valid, out_ch, out_data); end
    endtask

    task automatic test_random();
        logic [3:0] exp_r;
        for (int k = 0; k < 400; k++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_r = m_exp_ready();
            compared++;
            if (in_ready !== exp_r) begin mismatched++; $display("FAIL rand_ready[%0d] got %b want %b", k, in_ready, exp_r); end
            tick();
            compared++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch)) begin
                mismatched++;
                $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                         k, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
    endtask

    task automatic test_boundary_n3();
        rst3_n = 1'b0; in_valid3 = 3'b111; in_data3 = 24'hCCBBAA;
        mode3 = 1'b0; sel3 = 2'd1; out_ready3 = 1'b1;
        tick(); rst3_n = 1'b1; tick();
        compared++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd1 || out_data3 !== 8'hBB) begin mismatched++; $display("FAIL n3_load got v=%b ch=%0d d=%h want v=1 ch=1 d=bb", out_valid3, out_ch3, out_data3); end
        sel3 = 2'd3; out_ready3 = 1'b0; #1;
        compared++; if (in_ready3 !== 3'b000) begin mismatched++; $display("FAIL n3_sel3_ready got %b want 000", in_ready3); end
        tick();
        compared++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd1 || out_data3 !== 8'hBB) begin mismatched++; $display("FAIL n3_sel3_hold got v=%b ch=%0d d=%h want v=1 ch=1 d=bb", out_valid3, out_ch3, out_data3); end
        out_ready3 = 1'b1; #1;
        compared++; if (in_ready3 !== 3'b000) begin mismatched++; $display("FAIL n3_sel3_drain_ready got %b want 000", in_ready3); end
        tick();
        compared++; if (out_valid3 !== 1'b0 || out_ch3 !== 2'd1 || out_data3 !== 8'hBB) begin mismatched++; $display("FAIL n3_drain got v=%b ch=%0d d=%h want v=0 ch=1 d=bb", out_valid3, out_ch3, out_data3); end
        sel3 = 2'd2; tick();
        compared++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 8'hCC) begin mismatched++; $display("FAIL n3_sel2 got v=%b ch=%0d d=%h want v=1 ch=2 d=cc", out_valid3, out_ch3, out_data3); end
        out_ready3 = 1'b0; rst3_n = 1'b0; tick();
        compared++; if (out_valid3 !== 1'b0 || out_ch3 !== 2'd0 || out_data3 !== 8'h00) begin mismatched++; $display("FAIL n3_midreset got v=%b ch=%0d d=%h want v=0 ch=0 d=00", out_valid3, out_ch3, out_data3); end
        rst3_n = 1'b1; mode3 = 1'b1; out_ready3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (out_valid3 !== 1'b1 || out_ch3 !== 2'(k % 3)) begin
                mismatched++; $display("FAIL n3_rr_wrap[%0d] got v=%b ch=%0d want v=1 ch=%0d", k, out_valid3, out_ch3, k % 3);
            end
        end
    endtask

    initial begin
        rst3_n = 1'b0; in_valid3 = 3'b000; in_data3 = 24'h0; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
        test_reset();
        test_rr_fairness();
        test_rr_skip();
        test_fixed();
        test_backpressure();
        test_random();
        rst_n = 1'b1; in_valid = 4'h0; out_ready = 1'b1;
        test_boundary_n3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
